// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: RegDesloc commands, shift op codes
// and the sequencer state encoding.
package shift_sequencer_pkg;

  localparam logic [2:0] SH_NOP  = 3'b000;
  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_SLL  = 3'b010;
  localparam logic [2:0] SH_SRL  = 3'b011;
  localparam logic [2:0] SH_SRA  = 3'b100;
  localparam logic [2:0] SH_ROR  = 3'b101;
  localparam logic [2:0] SH_ROL  = 3'b110;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/shift_sequencer_op_decode.sv
// Maps a shift_op code onto the RegDesloc shift command; codes 5..7 flag illegal.
module shift_op_decode
  import shift_sequencer_pkg::*;
(
  input  logic [2:0] shift_op_i,
  output logic [2:0] cmd_o,
  output logic       illegal_o
);

  always_comb begin
    cmd_o     = SH_NOP;
    illegal_o = 1'b0;
    case (shift_op_i)
      OP_SLL:  cmd_o = SH_SLL;
      OP_SRL:  cmd_o = SH_SRL;
      OP_SRA:  cmd_o = SH_SRA;
      OP_ROR:  cmd_o = SH_ROR;
      OP_ROL:  cmd_o = SH_ROL;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences the RegDesloc shifter (load, shift, settle) on a single start request
// and pulses done when ALUOut holds the result.
//
// state  | meaning
// IDLE   | waiting for start; shifter idle
// LOAD   | shifter loads operand (one cycle)
// SHIFT  | latched shift command issued (one cycle)
// SETTLE | NOP cycles until SETTLE_CYCLES have elapsed
// DONE   | done pulse (with err for an illegal op), then IDLE
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] shift_op,
  input  logic       amt_sel,
  input  logic       flush,
  output logic [2:0] shifter_control,
  output logic       m_shifter,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [2:0] cmd_q;
  logic [2:0] cnt_q;
  logic [2:0] ctrl_q;
  logic       m_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;

  logic [2:0] dec_cmd;
  logic       dec_illegal;

  shift_op_decode u_decode (
    .shift_op_i (shift_op),
    .cmd_o      (dec_cmd),
    .illegal_o  (dec_illegal)
  );

  // Outputs are registered alongside the state, so each reflects the state entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= SH_NOP;
      cnt_q   <= 3'd0;
      ctrl_q  <= SH_NOP;
      m_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ctrl_q <= SH_NOP;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (start && !flush) begin
            busy_q <= 1'b1;
            if (dec_illegal) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              cmd_q   <= dec_cmd;
              m_q     <= amt_sel;
              ctrl_q  <= SH_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_SHIFT;
            ctrl_q  <= cmd_q;
          end
        end
        ST_SHIFT: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_SETTLE;
            cnt_q   <= 3'd0;
          end
        end
        ST_SETTLE: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign shifter_control = ctrl_q;
  assign m_shifter       = m_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two instances (SETTLE_CYCLES 1 and 3) checked every
// cycle against a timeline model, plus directed literal expectations.
module tb_shift_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] shift_op;
  logic       amt_sel;
  logic       flush;

  logic [2:0] ctrl1, ctrl3;
  logic       m1, m3, busy1, busy3, done1, done3, err1, err3;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 0;

  shift_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .shift_op(shift_op),
    .amt_sel(amt_sel), .flush(flush), .shifter_control(ctrl1),
    .m_shifter(m1), .busy(busy1), .done(done1), .err(err1)
  );

  shift_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .shift_op(shift_op),
    .amt_sel(amt_sel), .flush(flush), .shifter_control(ctrl3),
    .m_shifter(m3), .busy(busy3), .done(done3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: an operation is a timeline of cycles after the accepting edge.
  // pos 0 = load, 1 = shift, 2..S+1 = settle, S+2 = done; -1 = idle.
  int         pos  [2] = '{-1, -1};
  bit         ill  [2];
  logic [2:0] mcmd [2];
  logic       mlat [2];

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  always @(negedge reset) begin
    pos[0] = -1;
    pos[1] = -1;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset !== 1'b1) pos[k] = -1;
      else if (pos[k] < 0) begin
        if (start && !flush) begin
          if (shift_op > 3'd4) begin
            ill[k] = 1'b1;
            pos[k] = settle_of(k) + 2;
          end else begin
            ill[k]  = 1'b0;
            pos[k]  = 0;
            mcmd[k] = shift_op + 3'd2;
            mlat[k] = amt_sel;
          end
        end
      end else if (pos[k] == settle_of(k) + 2) pos[k] = -1;
      else if (flush) pos[k] = -1;
      else pos[k] = pos[k] + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [2:0] e_ctrl;
        logic e_busy, e_done, e_err;
        logic [2:0] a_ctrl;
        logic a_busy, a_done, a_err, a_m;
        e_ctrl = 3'd0;
        e_busy = (pos[k] >= 0);
        e_done = (pos[k] == settle_of(k) + 2);
        e_err  = e_done && ill[k];
        if (pos[k] == 0 && !ill[k]) e_ctrl = 3'b001;
        if (pos[k] == 1 && !ill[k]) e_ctrl = mcmd[k];
        a_ctrl = (k == 0) ? ctrl1 : ctrl3;
        a_busy = (k == 0) ? busy1 : busy3;
        a_done = (k == 0) ? done1 : done3;
        a_err  = (k == 0) ? err1  : err3;
        a_m    = (k == 0) ? m1    : m3;
        chk($sformatf("model_ctrl[%0d]", k), {29'd0, a_ctrl}, {29'd0, e_ctrl});
        chk($sformatf("model_busy[%0d]", k), {31'd0, a_busy}, {31'd0, e_busy});
        chk($sformatf("model_done[%0d]", k), {31'd0, a_done}, {31'd0, e_done});
        chk($sformatf("model_err[%0d]", k),  {31'd0, a_err},  {31'd0, e_err});
        if (pos[k] >= 0 && !ill[k])
          chk($sformatf("model_m[%0d]", k), {31'd0, a_m}, {31'd0, mlat[k]});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [2:0] seq1 [0:3];
  logic [2:0] seq3 [0:5];
  logic [2:0] seqh [0:5];
  logic       busyh [0:5];
  int         dcnt;

  initial begin
    reset = 1'bx;
    #0 reset = 1'b0;
    start = 1'b0; flush = 1'b0; shift_op = 3'd0; amt_sel = 1'b0;
    #1;
    chk("reset_ctrl", {29'd0, ctrl1}, 32'd0);
    chk("reset_busy", {30'd0, busy1, busy3}, 32'd0);
    chk("reset_done_err", {28'd0, done1, done3, err1, err3}, 32'd0);
    chk("reset_m", {30'd0, m1, m3}, 32'd0);
    cmp_en = 1;
    repeat (2) step();
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_outputs", {22'd0, ctrl1, ctrl3, busy1, busy3, done1, done3}, 32'd0);
    end

    // SLL from SHAMT: 001,010,000 then done after E3
    seq1[0] = 3'b001; seq1[1] = 3'b010; seq1[2] = 3'b000; seq1[3] = 3'b000;
    start = 1'b1; shift_op = 3'd0; amt_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      chk($sformatf("sll_ctrl_e%0d", i), {29'd0, ctrl1}, {29'd0, seq1[i]});
      chk($sformatf("sll_done_e%0d", i), {31'd0, done1}, {31'd0, (i == 3)});
      chk($sformatf("sll_busy_e%0d", i), {31'd0, busy1}, 32'd1);
    end
    step();
    chk("sll_idle_after", {30'd0, busy1, done1}, 32'd0);
    repeat (4) step();

    // SRA from register on SETTLE_CYCLES=3: done after E5, m_shifter held at 1
    seq3[0] = 3'b001; seq3[1] = 3'b100; seq3[2] = 3'b000;
    seq3[3] = 3'b000; seq3[4] = 3'b000; seq3[5] = 3'b000;
    start = 1'b1; shift_op = 3'd2; amt_sel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      start = 1'b0;
      amt_sel = 1'b0;
      chk($sformatf("sra_ctrl_e%0d", i), {29'd0, ctrl3}, {29'd0, seq3[i]});
      chk($sformatf("sra_m_e%0d", i), {31'd0, m3}, 32'd1);
      chk($sformatf("sra_done_e%0d", i), {31'd0, done3}, {31'd0, (i == 5)});
    end
    step();
    chk("sra_idle_after", {30'd0, busy3, done3}, 32'd0);
    repeat (3) step();

    // Illegal op: done+err after E0, shifter never commanded
    start = 1'b1; shift_op = 3'd6;
    step();
    start = 1'b0; shift_op = 3'd0;
    chk("illegal_done_err", {28'd0, done1, err1, done3, err3}, 32'hF);
    chk("illegal_ctrl", {26'd0, ctrl1, ctrl3}, 32'd0);
    chk("illegal_busy", {30'd0, busy1, busy3}, 32'd3);
    step();
    chk("illegal_after", {26'd0, busy1, busy3, done1, done3, err1, err3}, 32'd0);
    repeat (3) step();

    // Flush in SHIFT with start held throughout
    start = 1'b1; shift_op = 3'd1;
    step();
    chk("flush_load", {29'd0, ctrl1}, 32'd1);
    step();
    chk("flush_shift_no_restart", {29'd0, ctrl1}, 32'b011);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", {26'd0, ctrl1, busy1, done1, err1}, 32'd0);
    step();
    start = 1'b0;
    chk("flush_restart_in_idle", {29'd0, ctrl1}, 32'b001);
    repeat (8) step();

    // start and flush together in IDLE: nothing starts
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    chk("start_flush_idle", {30'd0, busy1, busy3}, 32'd0);
    repeat (2) step();

    // start held across completion: one IDLE cycle, then accepted again
    seqh[0] = 3'b001; seqh[1] = 3'b101; seqh[2] = 3'b000;
    seqh[3] = 3'b000; seqh[4] = 3'b000; seqh[5] = 3'b001;
    busyh[0] = 1'b1; busyh[1] = 1'b1; busyh[2] = 1'b1;
    busyh[3] = 1'b1; busyh[4] = 1'b0; busyh[5] = 1'b1;
    start = 1'b1; shift_op = 3'd3;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("held_ctrl_e%0d", i), {29'd0, ctrl1}, {29'd0, seqh[i]});
      chk($sformatf("held_busy_e%0d", i), {31'd0, busy1}, {31'd0, busyh[i]});
    end
    start = 1'b0;
    repeat (10) step();

    // Async reset during SETTLE clears outputs without a clock
    start = 1'b1; shift_op = 3'd0; amt_sel = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    chk("pre_reset_settle", {27'd0, ctrl3, busy3, m3}, 32'b00011);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_ctrl", {26'd0, ctrl1, ctrl3}, 32'd0);
    chk("async_reset_flags", {26'd0, busy1, busy3, done1, done3, m1, m3}, 32'd0);
    step();
    step();
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done1 || done3 || busy1 || busy3) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
